// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants, grant type and pointer helper for the write-back arbiter.
// Purely declarative; no logic, no latency, no flow control.
package wb_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_REQ    = 3;

  // Writes to this index are consumed but never reach the register file
  localparam int REG_ZERO = 0;

  typedef logic [DEF_NUM_REQ-1:0] grant_t;

  function automatic int unsigned next_ptr(input int unsigned g,
                                           input int unsigned n = DEF_NUM_REQ);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Round-robin picker: first valid index at or above ptr, wrapping mod N.
// Latency: combinational. Backpressure: none, caller gates the grant.
// Outputs a one-hot grant, its encoded index and an any-valid flag.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any_valid
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      cand = sum[PW-1:0];
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  assign any_valid = |valid;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port; WB_BYPASS_EN adds operand bypass.
// Latency: 1 cycle from grant to reg_write_o. Backpressure: wb_hold_i freezes the stage and grants nothing.
// Ready is a combinational one-hot grant; requesters hold rd/data stable until granted.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          wb_hold_i,
  output logic                          reg_write_o,
  output logic [ADDR_WIDTH-1:0]         rd_o,
  output logic [DATA_WIDTH-1:0]         write_data_o,
  input  logic [ADDR_WIDTH-1:0]         rs1_i,
  input  logic [ADDR_WIDTH-1:0]         rs2_i,
  input  logic [DATA_WIDTH-1:0]         rf_data1_i,
  input  logic [DATA_WIDTH-1:0]         rf_data2_i,
  output logic [DATA_WIDTH-1:0]         data1_o,
  output logic [DATA_WIDTH-1:0]         data2_o
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         pick_idx;
  logic [NUM_REQ-1:0]    pick_grant;
  logic                  pick_any;
  logic                  grant_en;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .valid     (req_valid_i),
    .ptr       (ptr),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // rst_n in the gate keeps ready low for the whole reset, not just after an edge
  assign grant_en    = rst_n & ~wb_hold_i & pick_any;
  assign req_ready_o = grant_en ? pick_grant : '0;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_rd   = req_rd_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_o  <= 1'b0;
      rd_o         <= '0;
      write_data_o <= '0;
      ptr          <= '0;
    end else if (grant_en) begin
      reg_write_o  <= (sel_rd != ADDR_WIDTH'(REG_ZERO));
      rd_o         <= sel_rd;
      write_data_o <= sel_data;
      ptr          <= PW'(next_ptr(32'(pick_idx), NUM_REQ));
    end else if (!wb_hold_i) begin
      // Idle: drop the enable but leave index/data as they were
      reg_write_o <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the in-flight write until the register file's negedge write lands
  assign data1_o = (reg_write_o && rd_o == rs1_i && rs1_i != ADDR_WIDTH'(REG_ZERO))
                   ? write_data_o : rf_data1_i;
  assign data2_o = (reg_write_o && rd_o == rs2_i && rs2_i != ADDR_WIDTH'(REG_ZERO))
                   ? write_data_o : rf_data2_i;
`else
  logic unused_rs;
  assign unused_rs = ^{rs1_i, rs2_i};
  assign data1_o   = rf_data1_i;
  assign data2_o   = rf_data2_i;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios then randomized traffic.
module tb_regfile_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid_i;
  logic [N*AW-1:0]   req_rd_i;
  logic [N*DW-1:0]   req_data_i;
  logic [N-1:0]      req_ready_o;
  logic              wb_hold_i;
  logic              reg_write_o;
  logic [AW-1:0]     rd_o;
  logic [DW-1:0]     write_data_o;
  logic [AW-1:0]     rs1_i, rs2_i;
  logic [DW-1:0]     rf_data1_i, rf_data2_i;
  logic [DW-1:0]     data1_o, data2_o;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REQ    (N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_rd_i     (req_rd_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .wb_hold_i    (wb_hold_i),
    .reg_write_o  (reg_write_o),
    .rd_o         (rd_o),
    .write_data_o (write_data_o),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .rf_data1_i   (rf_data1_i),
    .rf_data2_i   (rf_data2_i),
    .data1_o      (data1_o),
    .data2_o      (data2_o)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  wb_exp_t mon_e;
  int      n_checks = 0;
  int      n_fail   = 0;

  // Reference model: pending requests, round-robin start point, expected write-port contents
  bit            v[N];
  logic [AW-1:0] r[N];
  logic [DW-1:0] d[N];
  bit            hold;
  bit            auto_drop;
  int            mptr;
  wb_exp_t       mout;
  int            wait_cnt[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_operand(input logic [AW-1:0] rs, input logic [DW-1:0] rf);
`ifdef WB_BYPASS_EN
    if (mout.we && mout.rd == rs && rs != '0) return mout.data;
`endif
    return rf;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid_i[i]          = v[i];
      req_rd_i[i*AW +: AW]    = r[i];
      req_data_i[i*DW +: DW]  = d[i];
    end
    wb_hold_i = hold;
  endtask

  task automatic step();
    int     g;
    int     j;
    grant_t eg;
    @(negedge clk);
    drive();
    #1;
    chk("data1", 64'(data1_o), 64'(exp_operand(rs1_i, rf_data1_i)));
    chk("data2", 64'(data2_o), 64'(exp_operand(rs2_i, rf_data2_i)));
    g = -1;
    if (!hold) begin
      for (int k = 0; k < N; k++) begin
        j = (mptr + k) % N;
        if (g < 0 && v[j]) g = j;
      end
    end
    eg = (g >= 0) ? (grant_t'(1) << g) : '0;
    chk("ready", 64'(req_ready_o), 64'(eg));
    if (req_ready_o != '0) begin
      for (int i = 0; i < N; i++) begin
        if (req_ready_o[i]) begin
          chk("fair_wait", 64'(wait_cnt[i] <= N - 1), 64'(1));
          wait_cnt[i] = 0;
        end else if (v[i]) begin
          wait_cnt[i]++;
        end
      end
    end
    for (int i = 0; i < N; i++) if (!v[i]) wait_cnt[i] = 0;
    if (!hold) begin
      if (g >= 0) begin
        mout.we   = (r[g] != '0);
        mout.rd   = r[g];
        mout.data = d[g];
        mptr      = (g + 1) % N;
        if (auto_drop) v[g] = 1'b0;
      end else begin
        mout.we = 1'b0;
      end
    end
    exp_q.push_back(mout);
  endtask

  task automatic model_reset();
    mptr = 0;
    mout = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // Monitor: one expected write-port state per clock after each issued step
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("wb_we",   64'(reg_write_o),  64'(mon_e.we));
        chk("wb_rd",   64'(rd_o),         64'(mon_e.rd));
        chk("wb_data", 64'(write_data_o), 64'(mon_e.data));
      end
    end
  end

  initial begin
    hold = 1'b0; auto_drop = 1'b0;
    rs1_i = '0; rs2_i = '0; rf_data1_i = '0; rf_data2_i = '0;
    model_reset();
    v = '{1'b1, 1'b1, 1'b1};
    r = '{5'd1, 5'd2, 5'd3};
    d = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
    drive();

    // Reset with every requester valid
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready_o),  64'(0));
    chk("rst_we",    64'(reg_write_o),  64'(0));
    chk("rst_rd",    64'(rd_o),         64'(0));
    chk("rst_data",  64'(write_data_o), 64'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;

    // First grant to req0, then steady rotation across all three
    repeat (7) step();

    // x0 write is consumed but never enables the register file
    v = '{1'b0, 1'b1, 1'b0};
    r[1] = 5'd0; d[1] = 32'h0000_DEAD;
    step();

    // Hold freezes grant, stage and pointer; req2 wins on release
    v = '{1'b1, 1'b0, 1'b1};
    r[0] = 5'd4; d[0] = 32'h4444_0000;
    r[2] = 5'd7; d[2] = 32'h7777_0000;
    hold = 1'b1;
    repeat (3) step();
    hold = 1'b0;
    step();

    // Operand path with a live write to r5
    v = '{1'b1, 1'b0, 1'b0};
    r[0] = 5'd5; d[0] = 32'h0000_1234;
    step();
    v = '{1'b0, 1'b0, 1'b0};
    hold = 1'b1;
    rs1_i = 5'd5; rf_data1_i = 32'h0; rs2_i = 5'd3; rf_data2_i = 32'hBEEF;
    step();
    rs1_i = 5'd0; rf_data1_i = 32'h55; rs2_i = 5'd5; rf_data2_i = 32'h0;
    step();
    hold = 1'b0;

    // Async reset while req2 is being granted: the grant is lost
    v = '{1'b0, 1'b0, 1'b1};
    r[2] = 5'd9; d[2] = 32'h9999_0009;
    step();
    @(negedge clk);
    drive();
    #1;
    chk("pre_rst_ready", 64'(req_ready_o), 64'(3'b100));
    chk("pre_rst_we",    64'(reg_write_o), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_we",    64'(reg_write_o),  64'(0));
    chk("async_rst_rd",    64'(rd_o),         64'(0));
    chk("async_rst_data",  64'(write_data_o), 64'(0));
    chk("async_rst_ready", 64'(req_ready_o),  64'(0));
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    v = '{1'b1, 1'b1, 1'b1};
    repeat (2) step();

    // Randomized traffic with retire-on-grant requesters
    auto_drop = 1'b1;
    v = '{1'b0, 1'b0, 1'b0};
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 2) != 0) begin
          v[i] = 1'b1;
          r[i] = AW'($urandom_range(0, 7));
          d[i] = $urandom;
        end
      end
      hold       = ($urandom_range(0, 4) == 0);
      rs1_i      = AW'($urandom_range(0, 7));
      rs2_i      = AW'($urandom_range(0, 7));
      rf_data1_i = $urandom;
      rf_data2_i = $urandom;
      step();
    end
    hold = 1'b0;
    v = '{1'b0, 1'b0, 1'b0};
    step();
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
